// File: rtl/nes_controller_responder_if.sv
// Host-facing signals of the NES controller responder: button inputs,
// the host's latch/pulse lines and the serial reply with its status strobes.
interface nes_controller_responder_if;
  logic [7:0] buttons_in;
  logic       latch_in;
  logic       pulse_in;
  logic       data_out;
  logic       frame_done;
  logic       busy;

  modport slave (
    input  buttons_in,
    input  latch_in,
    input  pulse_in,
    output data_out,
    output frame_done,
    output busy
  );

  modport master (
    output buttons_in,
    output latch_in,
    output pulse_in,
    input  data_out,
    input  frame_done,
    input  busy
  );
endinterface

// File: rtl/nes_controller_responder.sv
// Emulates an NES pad's 4021 shift register: latch captures the buttons,
// host pulses shift them out active-low, LSB (A) first.
//
// state | meaning
// IDLE  | waiting for a latch, data_out held high
// LOAD  | latch high, buttons reloaded every cycle
// SHIFT | frame in progress, one bit per host pulse edge
// DONE  | all 8 bits sent, data_out low until the next latch
module nes_controller_responder #(
  parameter int LATCH_MIN_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 400000
) (
  input logic                     clk,
  input logic                     reset,
  nes_controller_responder_if.slave bus
);

  localparam int LCW = $clog2(LATCH_MIN_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LCW-1:0] LATCH_MIN = LCW'(LATCH_MIN_CYCLES);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     shreg;
  logic [3:0]     bit_cnt;
  logic [LCW-1:0] latch_cnt;
  logic [TW-1:0]  tmo_cnt;

  logic latch_s1, latch_s2, latch_s3;
  logic pulse_s1, pulse_s2, pulse_s3;
  logic latch_high, latch_fell, pulse_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_s3 <= 1'b0;
      pulse_s1 <= 1'b0;
      pulse_s2 <= 1'b0;
      pulse_s3 <= 1'b0;
    end else begin
      latch_s1 <= bus.latch_in;
      latch_s2 <= latch_s1;
      latch_s3 <= latch_s2;
      pulse_s1 <= bus.pulse_in;
      pulse_s2 <= pulse_s1;
      pulse_s3 <= pulse_s2;
    end
  end

  assign latch_high = latch_s2;
  assign latch_fell = latch_s3 & ~latch_s2;
  assign pulse_rise = pulse_s2 & ~pulse_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= 8'h00;
      bit_cnt        <= 4'd0;
      latch_cnt      <= '0;
      tmo_cnt        <= '0;
      bus.data_out   <= 1'b1;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      // Latch has priority in every state, including over a same-cycle pulse edge.
      if (latch_high) begin
        state        <= LOAD;
        bus.busy     <= 1'b1;
        shreg        <= ~bus.buttons_in;
        bus.data_out <= ~bus.buttons_in[0];
        if (state != LOAD)
          latch_cnt <= LCW'(1);
        else if (latch_cnt != LATCH_MIN)
          latch_cnt <= latch_cnt + LCW'(1);
      end else begin
        case (state)
          LOAD: begin
            if (latch_fell) begin
              if (latch_cnt >= LATCH_MIN) begin
                state   <= SHIFT;
                bit_cnt <= 4'd0;
                tmo_cnt <= '0;
              end else begin
                state        <= IDLE;
                bus.data_out <= 1'b1;
                bus.busy     <= 1'b0;
              end
            end
          end
          SHIFT: begin
            if (pulse_rise) begin
              shreg        <= {1'b0, shreg[7:1]};
              bus.data_out <= shreg[1];
              bit_cnt      <= bit_cnt + 4'd1;
              tmo_cnt      <= '0;
              if (bit_cnt == 4'd7) begin
                state          <= DONE;
                bus.data_out   <= 1'b0;
                bus.frame_done <= 1'b1;
                bus.busy       <= 1'b0;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              state        <= IDLE;
              bus.data_out <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
